// File: rtl/node_sigma.sv
// node_sigma: run-length coalescing output stage fed by node_rho.bundle_out.
// Latency: a closed run reaches out_* one cycle after the edge that closes it.
//          A run closes on a differing word, a 255th repeat plus one more word, or a flush.
// Backpressure: in_ready = !full && !flush. A full FIFO stalls input, and a pending flush
//               waits for a free slot or for a pop on the same edge.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   bundle_in, in_valid   input word stream from node_rho
//   in_ready              this stage accepts a word this cycle
//   flush                 close the pending run and enqueue it
//   out_data, out_len     run at the FIFO head (both 0 while out_valid is low)
//   out_valid, out_ready  output handshake toward the sink
//   fill_level            FIFO occupancy, 0..DEPTH
//   csum                  rotate-XOR checksum of popped words
//
// Optional feature: define NODE_SIGMA_CSUM_EN to build the checksum register.
// Without that macro, csum is tied to 0.

module node_sigma #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         bundle_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [WIDTH-1:0]         out_data,
  output logic [7:0]               out_len,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [WIDTH-1:0]         csum
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] word;
    logic [7:0]       len;
  } entry_t;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] run_word_q, run_word_d;
  logic [7:0]       run_len_q, run_len_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  entry_t           mem [DEPTH];
  entry_t           head;

  logic full;
  logic accept;
  logic pop;
  logic push;
  logic flush_go;
  logic same_word;
  logic len_max;

  // ------------------------------------------------------------------
  // Handshake decode
  // ------------------------------------------------------------------
  assign full      = (count_q == CW'(DEPTH));
  assign in_ready  = !full && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign same_word = (bundle_in == run_word_q);
  assign len_max   = (run_len_q == 8'd255);

  // A flush can always push when a slot is free. When the FIFO is full,
  // it can still push if the head is popped on the same edge: the write
  // reuses the slot that the pop releases.
  assign flush_go  = flush && (!full || pop);

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // accept and flush_go are mutually exclusive, because flush forces in_ready low.
        if (flush_go) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: outputs (push strobe and pending-run updates)
  // ------------------------------------------------------------------
  always_comb begin
    push       = 1'b0;
    run_word_d = run_word_q;
    run_len_d  = run_len_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          run_word_d = bundle_in;
          run_len_d  = 8'd1;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (same_word && !len_max) begin
            run_len_d = run_len_q + 8'd1;
          end else begin
            // Close the current run and open a new run with the incoming word.
            push       = 1'b1;
            run_word_d = bundle_in;
            run_len_d  = 8'd1;
          end
        end else if (flush_go) begin
          push = 1'b1;
        end
      end
      default: begin
        push = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_word_q <= '0;
      run_len_q  <= '0;
    end else begin
      run_word_q <= run_word_d;
      run_len_q  <= run_len_d;
    end
  end

  // ------------------------------------------------------------------
  // Circular FIFO
  // ------------------------------------------------------------------
  // The storage array has no reset. Reset clears count_q, which marks
  // every entry as invalid, and out_* is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= '{word: run_word_q, len: run_len_q};
    end
  end

  always_comb begin
    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head       = mem[rd_ptr_q];
  assign out_data   = out_valid ? head.word : '0;
  assign out_len    = out_valid ? head.len  : '0;
  assign fill_level = count_q;

  // ------------------------------------------------------------------
  // Checksum of popped words (optional)
  // ------------------------------------------------------------------
`ifdef NODE_SIGMA_CSUM_EN
  logic [WIDTH-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (pop) begin
      csum_d = {csum_q[WIDTH-2:0], csum_q[WIDTH-1]} ^ out_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

endmodule

// File: doc/node_sigma.md
# node_sigma

Run-length coalescing output stage that sits directly downstream of `node_rho`: it consumes the `bundle_out` word stream, collapses consecutive identical words into (word, length) runs, and buffers completed runs in a small FIFO toward the sink with a valid/ready handshake. It decouples `node_rho`'s per-cycle output from a slower, back-pressuring consumer and reduces traffic on repetitive data.

## Interface
Parameters:
- `WIDTH`, 32: data word width; equals `node_rho` `WIDTH`.
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bundle_in`  in  WIDTH  input word, driven from `node_rho.bundle_out`.
- `in_valid`  in  1  `bundle_in` is valid this cycle.
- `in_ready`  out  1  stage accepts a word this cycle.
- `flush`  in  1  request to close and enqueue the pending run.
- `out_data`  out  WIDTH  run word at the FIFO head.
- `out_len`  out  8  run length at the FIFO head, range 1..255.
- `out_valid`  out  1  the FIFO head is valid.
- `out_ready`  in  1  the sink accepts the head.
- `fill_level`  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- `csum`  out  WIDTH  checksum of popped words (see Configuration).

## Operation
- A word is accepted when `in_valid && in_ready`. A FIFO pop occurs when `out_valid && out_ready`.
- `in_ready = !full && !flush`, where `full = (fill_level == DEPTH)`. `in_ready` is combinational from registered state and `flush` only; it never depends on `in_valid`.
- Pending-run register holds `run_word` (WIDTH bits) and `run_len` (8 bits). The state machine has two states:
  - `EMPTY`: no run is pending. An accepted word sets `run_word = word`, `run_len = 1`, and moves to `RUN`.
  - `RUN`, accepted word equal to `run_word` and `run_len < 255`: `run_len` increments; state stays `RUN`.
  - `RUN`, accepted word differs from `run_word` or `run_len == 255`: push {`run_word`, `run_len`} into the FIFO, start a new run {word, 1}, stay in `RUN`.
  - `RUN`, `flush` high with `!full`: push the pending run and go to `EMPTY`.
  - `RUN`, `flush` high with `full`: hold until space frees. `flush` must stay high until the push happens.
  - `EMPTY`, `flush` high: no effect.
- Every push needs only one slot. `in_ready` requires `!full`, so a push is never lost.
- FIFO is a circular buffer with `DEPTH` entries and wrapping read/write pointers.
- Push and pop in the same cycle: `fill_level` is unchanged. This is legal even when `full`, because `in_ready` is low when full, so only a flush push can coincide there.
- While `out_valid` is low, `out_data` and `out_len` drive 0.
- `out_data` and `out_len` hold stable while `out_valid && !out_ready`.

## Timing
- Reset values:
  - `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `out_len` = 0, `fill_level` = 0, `csum` = 0.
  - State = `EMPTY`, pointers = 0.
- Reset asserted mid-operation discards the pending run and all FIFO contents immediately, asynchronously.
- Push to visibility: an entry pushed at edge N is visible on `out_*` with `out_valid` high after edge N. Latency from the run-closing event to `out_valid` is 1 cycle.
- Overall latency is data dependent: a run surfaces only after a differing word, the 255th repeat plus one more word, or a flush.
- `fill_level` updates at the same edge as the push or pop.
- Throughput: one accepted word per cycle and one pop per cycle.

## Configuration
- `NODE_SIGMA_CSUM_EN` defined: on every pop, `csum <= {csum[WIDTH-2:0], csum[WIDTH-1]} ^ out_data`, i.e. rotate left by 1, then XOR. `csum` is cleared only by reset.
- `NODE_SIGMA_CSUM_EN` not defined: `csum` is tied to 0 and no checksum register is synthesised.

## Test plan
- Reset, then idle for 5 cycles -> `in_ready`=1, `out_valid`=0, `fill_level`=0, all outputs 0.
- Feed words A, A, A, B, then `flush` with `out_ready`=1 -> pops {A,3}, then {B,1}; `fill_level` returns to 0.
- Feed 300 consecutive copies of 0x5 with `out_ready`=1, then flush -> pops {0x5,255}, then {0x5,45}.
- Hold `out_ready`=0 and feed alternating 0x1/0x2 -> after 8 pushes `fill_level`=8 and `in_ready`=0; raising `out_ready` pops entries in order, all with `out_len`=1, and `in_ready` rises the cycle after the first pop.
- Full FIFO plus pending run, `flush` held, then one pop -> the flush push and the pop land on the same edge; `fill_level` stays 8 and the state becomes `EMPTY`.
- With `NODE_SIGMA_CSUM_EN` defined: pop words 0x1, then 0x1 (WIDTH=32) -> `csum` = 0x1, then 0x3. Assert `rst_n` low mid-stream -> all outputs return to their reset values.
